// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end: widths, FSM encoding and
// the fetch-queue entry layout.
package fetch_pkg;

    localparam int XLEN    = 32;
    localparam int ILEN    = 32;
    localparam int PC_STEP = 4;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
        logic            filled;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order circular buffer of fetches: entries are allocated at issue, filled
// by responses in request order, and popped from the head by decode.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            clear,
    input  logic            alloc,
    input  logic [XLEN-1:0] alloc_pc,
    input  logic            fill,
    input  logic [ILEN-1:0] fill_data,
    input  logic            pop,
    output fq_entry_t       head,
    output logic [AW:0]     count,
    output logic [AW:0]     unfilled
);

    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    fq_entry_t [DEPTH-1:0] mem;
    logic [AW:0]           head_ptr, tail_ptr, fill_ptr;
    logic                  do_fill;

    // Extra pointer bit distinguishes full from empty.
    assign count    = tail_ptr - head_ptr;
    assign unfilled = tail_ptr - fill_ptr;
    assign do_fill  = fill && (unfilled != '0);
    assign head     = mem[head_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            fill_ptr <= '0;
            mem      <= '0;
        end else if (clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            fill_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i].filled <= 1'b0;
        end else begin
            if (alloc) begin
                mem[tail_ptr[AW-1:0]].pc     <= alloc_pc;
                mem[tail_ptr[AW-1:0]].filled <= 1'b0;
                tail_ptr                     <= tail_ptr + PTR_ONE;
            end
            if (do_fill) begin
                mem[fill_ptr[AW-1:0]].inst   <= fill_data;
                mem[fill_ptr[AW-1:0]].filled <= 1'b1;
                fill_ptr                     <= fill_ptr + PTR_ONE;
            end
            if (pop) head_ptr <= head_ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: steps the pc register, issues imem requests, presents
// returned instructions to decode and drops stale fetches after a redirect.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [XLEN-1:0] pc,
    output logic            pc_pause,
    output logic [XLEN-1:0] pc_npc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [ILEN-1:0] if_inst,
    input  logic            if_ready,
    output logic            flush
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    fetch_state_e  state;
    fq_entry_t     head;
    logic [AW:0]   drop_cnt, drop_sum, q_count, q_unfilled;
    logic [AW+1:0] occ;
    logic          run, kill, fire, pop, fill;

    assign run  = (state == RUN);
    assign kill = run && redirect;

    // occ uses only registered counts, so if_ready never reaches req_valid.
    assign occ            = {1'b0, q_count} + {1'b0, drop_cnt};
    assign imem_req_valid = run && !redirect && (occ < (AW+2)'(DEPTH));
    assign imem_req_addr  = pc;
    assign fire           = imem_req_valid && imem_req_ready;

    assign flush    = kill;
    assign pc_pause = !(kill || fire);

    always_comb begin
        pc_npc = pc;
        if (kill)      pc_npc = redirect_pc;
        else if (fire) pc_npc = pc + XLEN'(PC_STEP);
    end

    assign if_valid = run && !redirect && head.filled && (q_count != '0);
    assign if_pc    = head.pc;
    assign if_inst  = head.inst;
    assign pop      = if_valid && if_ready;
    assign fill     = run && !redirect && imem_rsp_valid && (drop_cnt == '0);

    // Every fetch still in flight at a redirect must be swallowed later,
    // except one whose beat arrives in the redirect cycle itself.
    assign drop_sum = drop_cnt + q_unfilled;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= BOOT;
            drop_cnt <= '0;
        end else begin
            state <= RUN;
            if (kill) begin
                if (imem_rsp_valid && drop_sum != '0) drop_cnt <= drop_sum - CNT_ONE;
                else                                  drop_cnt <= drop_sum;
            end else if (run && imem_rsp_valid && drop_cnt != '0) begin
                drop_cnt <= drop_cnt - CNT_ONE;
            end
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (kill),
        .alloc     (fire),
        .alloc_pc  (pc),
        .fill      (fill),
        .fill_data (imem_rsp_data),
        .pop       (pop),
        .head      (head),
        .count     (q_count),
        .unfilled  (q_unfilled)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed per-cycle vectors for fetch_ctrl (DEPTH=2) plus hand sequences for
// bypass latency and asynchronous reset.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] pc = '0;
    logic        pc_pause;
    logic [31:0] pc_npc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready = 1'b1;
    logic        flush;

    always #5 clock = ~clock;

    fetch_ctrl #(.DEPTH(2)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .pc             (pc),
        .pc_pause       (pc_pause),
        .pc_npc         (pc_npc),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_ready       (if_ready),
        .flush          (flush)
    );

    // A beat with nothing outstanding and nothing to drop is a bench bug.
    always @(posedge clock)
        if (reset_n && dut.state == RUN && imem_rsp_valid && !redirect)
            assert (dut.drop_cnt != 0 || dut.q_unfilled != 0)
                else $error("protocol: response with no outstanding fetch");

    typedef struct {
        logic        rst_n;
        logic [31:0] pc;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        rspv;
        logic [31:0] rspd;
        logic        ifr;
        logic        pause;
        logic [31:0] npc;
        logic        reqv;
        logic        ifv;
        logic [31:0] ipc;
        logic [31:0] iinst;
        logic        fl;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [31:0] D0   = 32'h0000_0013;
    localparam logic [31:0] D4   = 32'h0040_0113;
    localparam logic [31:0] D8   = 32'h0080_0193;
    localparam logic [31:0] DC   = 32'h00c0_0213;
    localparam logic [31:0] D10  = 32'hDEAD_0010;
    localparam logic [31:0] D14  = 32'hDEAD_0014;
    localparam logic [31:0] D100 = 32'h1000_0293;
    localparam logic [31:0] D104 = 32'h1040_0313;
    localparam logic [31:0] D200 = 32'hDEAD_0200;
    localparam logic [31:0] D400 = 32'hDEAD_0400;
    localparam logic [31:0] DF   = 32'hFFC0_0393;
    localparam logic [31:0] D0B  = 32'h0000_0413;

    function automatic vec_t mk(
        logic rst_n, logic [31:0] pc_i, logic redir, logic [31:0] rpc,
        logic rdy, logic rspv, logic [31:0] rspd, logic ifr,
        logic pause, logic [31:0] npc, logic reqv, logic ifv,
        logic [31:0] ipc, logic [31:0] iinst, logic fl);
        vec_t v;
        v.rst_n = rst_n; v.pc = pc_i; v.redir = redir; v.rpc = rpc;
        v.rdy = rdy; v.rspv = rspv; v.rspd = rspd; v.ifr = ifr;
        v.pause = pause; v.npc = npc; v.reqv = reqv; v.ifv = ifv;
        v.ipc = ipc; v.iinst = iinst; v.fl = fl;
        return v;
    endfunction

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        reset_n        = v.rst_n;
        pc             = v.pc;
        redirect       = v.redir;
        redirect_pc    = v.rpc;
        imem_req_ready = v.rdy;
        imem_rsp_valid = v.rspv;
        imem_rsp_data  = v.rspd;
        if_ready       = v.ifr;
    endtask

    task automatic check(input int r, input vec_t v);
        chk("pc_pause",  r, 32'(pc_pause),       32'(v.pause));
        chk("pc_npc",    r, pc_npc,              v.npc);
        chk("req_valid", r, 32'(imem_req_valid), 32'(v.reqv));
        chk("req_addr",  r, imem_req_addr,       v.pc);
        chk("if_valid",  r, 32'(if_valid),       32'(v.ifv));
        chk("flush",     r, 32'(flush),          32'(v.fl));
        if (v.ifv) begin
            chk("if_pc",   r, if_pc,   v.ipc);
            chk("if_inst", r, if_inst, v.iinst);
        end
    endtask

    initial begin
        int lat;
        bit got;

        //                rst pc            rd rpc           rdy rv rdata ifr | pse npc          rqv ifv ipc           iinst fl
        vecs.push_back(mk(0, 32'h0,         0, 32'h0,        1, 0, 32'h0, 1,   1, 32'h0,        0, 0, 32'h0,        32'h0, 0)); // 0 reset
        vecs.push_back(mk(1, 32'h0,         0, 32'h0,        1, 0, 32'h0, 1,   1, 32'h0,        0, 0, 32'h0,        32'h0, 0)); // 1 BOOT
        vecs.push_back(mk(1, 32'h0,         0, 32'h0,        1, 0, 32'h0, 1,   0, 32'h4,        1, 0, 32'h0,        32'h0, 0)); // 2 fire 0
        vecs.push_back(mk(1, 32'h4,         0, 32'h0,        1, 1, D0,    1,   0, 32'h8,        1, 0, 32'h0,        32'h0, 0)); // 3 fire 4, fill 0
        vecs.push_back(mk(1, 32'h8,         0, 32'h0,        1, 1, D4,    1,   1, 32'h8,        0, 1, 32'h0,        D0,    0)); // 4 full, present 0
        vecs.push_back(mk(1, 32'h8,         0, 32'h0,        1, 0, 32'h0, 1,   0, 32'hC,        1, 1, 32'h4,        D4,    0)); // 5 fire 8, pop 4
        vecs.push_back(mk(1, 32'hC,         0, 32'h0,        1, 1, D8,    1,   0, 32'h10,       1, 0, 32'h0,        32'h0, 0)); // 6 fire C
        vecs.push_back(mk(1, 32'h10,        0, 32'h0,        1, 1, DC,    0,   1, 32'h10,       0, 1, 32'h8,        D8,    0)); // 7 stall
        vecs.push_back(mk(1, 32'h10,        0, 32'h0,        1, 0, 32'h0, 0,   1, 32'h10,       0, 1, 32'h8,        D8,    0)); // 8 stall
        vecs.push_back(mk(1, 32'h10,        0, 32'h0,        1, 0, 32'h0, 0,   1, 32'h10,       0, 1, 32'h8,        D8,    0)); // 9 stall
        vecs.push_back(mk(1, 32'h10,        0, 32'h0,        1, 0, 32'h0, 1,   1, 32'h10,       0, 1, 32'h8,        D8,    0)); // 10 pop, no issue yet
        vecs.push_back(mk(1, 32'h10,        0, 32'h0,        1, 0, 32'h0, 1,   0, 32'h14,       1, 1, 32'hC,        DC,    0)); // 11 pop + fire
        vecs.push_back(mk(1, 32'h14,        0, 32'h0,        1, 0, 32'h0, 1,   0, 32'h18,       1, 0, 32'h0,        32'h0, 0)); // 12 fire 14
        vecs.push_back(mk(1, 32'h18,        1, 32'h100,      1, 1, D10,   1,   0, 32'h100,      0, 0, 32'h0,        32'h0, 1)); // 13 redirect, 2 unfilled
        vecs.push_back(mk(1, 32'h100,       0, 32'h0,        1, 1, D14,   1,   0, 32'h104,      1, 0, 32'h0,        32'h0, 0)); // 14 stale beat dropped
        vecs.push_back(mk(1, 32'h104,       0, 32'h0,        1, 1, D100,  1,   0, 32'h108,      1, 0, 32'h0,        32'h0, 0)); // 15
        vecs.push_back(mk(1, 32'h108,       0, 32'h0,        1, 1, D104,  0,   1, 32'h108,      0, 1, 32'h100,      D100,  0)); // 16 first after redirect
        vecs.push_back(mk(1, 32'h108,       1, 32'h200,      1, 0, 32'h0, 1,   0, 32'h200,      0, 0, 32'h0,        32'h0, 1)); // 17 redirect vs pop
        vecs.push_back(mk(1, 32'h200,       0, 32'h0,        1, 0, 32'h0, 1,   0, 32'h204,      1, 0, 32'h0,        32'h0, 0)); // 18 no re-present
        vecs.push_back(mk(1, 32'h204,       1, 32'h300,      1, 0, 32'h0, 1,   0, 32'h300,      0, 0, 32'h0,        32'h0, 1)); // 19 back-to-back 1
        vecs.push_back(mk(1, 32'h300,       1, 32'h400,      1, 0, 32'h0, 1,   0, 32'h400,      0, 0, 32'h0,        32'h0, 1)); // 20 back-to-back 2
        vecs.push_back(mk(1, 32'h400,       0, 32'h0,        1, 1, D200,  1,   0, 32'h404,      1, 0, 32'h0,        32'h0, 0)); // 21 drop 0x200 beat
        vecs.push_back(mk(1, 32'h404,       1, 32'hFFFFFFFC, 1, 1, D400,  1,   0, 32'hFFFFFFFC, 0, 0, 32'h0,        32'h0, 1)); // 22 beat in redirect
        vecs.push_back(mk(1, 32'hFFFFFFFC,  0, 32'h0,        1, 0, 32'h0, 1,   0, 32'h0,        1, 0, 32'h0,        32'h0, 0)); // 23 pc wrap
        vecs.push_back(mk(1, 32'h0,         0, 32'h0,        1, 1, DF,    1,   0, 32'h4,        1, 0, 32'h0,        32'h0, 0)); // 24
        vecs.push_back(mk(1, 32'h4,         0, 32'h0,        1, 1, D0B,   0,   1, 32'h4,        0, 1, 32'hFFFFFFFC, DF,    0)); // 25 full
        vecs.push_back(mk(0, 32'h0,         0, 32'h0,        1, 0, 32'h0, 1,   1, 32'h0,        0, 0, 32'h0,        32'h0, 0)); // 26 reset while full
        vecs.push_back(mk(1, 32'h0,         0, 32'h0,        1, 0, 32'h0, 1,   1, 32'h0,        0, 0, 32'h0,        32'h0, 0)); // 27 BOOT
        vecs.push_back(mk(1, 32'h0,         0, 32'h0,        1, 0, 32'h0, 1,   0, 32'h4,        1, 0, 32'h0,        32'h0, 0)); // 28 first req at 0

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            apply(vecs[i]);
            #1;
            check(i, vecs[i]);
        end

        // Bypass: a beat filling an empty head shows up right after the fill edge.
        @(negedge clock);
        pc = 32'h4; imem_req_ready = 1'b0; redirect = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hABCD_0013; if_ready = 1'b0;
        #1;
        chk("noready_req_valid", 100, 32'(imem_req_valid), 32'd1);
        chk("noready_pause",     100, 32'(pc_pause),       32'd1);
        chk("prefill_if_valid",  100, 32'(if_valid),       32'd0);
        @(negedge clock);
        imem_rsp_valid = 1'b0;
        got = 1'b0;
        lat = 0;
        repeat (4) begin
            if (!got) begin
                #1;
                if (if_valid) got = 1'b1;
                else begin
                    lat++;
                    @(negedge clock);
                end
            end
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL row 101 bypass_timeout: if_valid never rose within 4 cycles");
        end
        chk("bypass_latency", 101, 32'(lat), 32'd0);
        chk("bypass_if_pc",   101, if_pc,    32'h0);
        chk("bypass_if_inst", 101, if_inst,  32'hABCD_0013);

        // Reset asserted mid-cycle, away from both edges, with an instruction presented.
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_if_valid",  102, 32'(if_valid),       32'd0);
        chk("async_req_valid", 102, 32'(imem_req_valid), 32'd0);
        chk("async_pause",     102, 32'(pc_pause),       32'd1);
        chk("async_npc",       102, pc_npc,              pc);
        @(negedge clock);
        pc = 32'h0; imem_req_ready = 1'b1; reset_n = 1'b1;
        #1;
        chk("release_boot_req_valid", 103, 32'(imem_req_valid), 32'd0);
        @(negedge clock);
        #1;
        chk("release_req_valid", 104, 32'(imem_req_valid), 32'd1);
        chk("release_req_addr",  104, imem_req_addr,       32'h0);
        chk("release_if_valid",  104, 32'(if_valid),       32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
